// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl
//   Game sequencer for the whack-a-mole board. It turns the 1 Hz divider
//   output and the debounced buttons into the lit-mole pattern. It owns the
//   score and seconds-remaining registers that the display scan renders.
//
//   State table (value on the state port):
//     state     | meaning
//     IDLE  (0) | waiting for start, no mole lit
//     SPAWN (1) | one cycle: pick and latch the next mole
//     UP    (2) | a mole is lit, waiting for a hit or for its time to expire
//     GAP   (3) | no mole lit, waiting for the next second
//     DONE  (4) | game over, score and time frozen until start
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-high reset
//     tick_1hz   in   1 Hz level from the clock divider (same clock domain)
//     start_btn  in   debounced start button (level)
//     hit_btn    in   debounced hit buttons, one per mole (level)
//     mole_led   out  one-hot lit mole, 0 when none
//     score      out  current score (saturating)
//     time_left  out  seconds remaining in the game
//     game_over  out  high while in DONE
//     state      out  current state code
module whack_game_ctrl #(
  parameter int          N_MOLES         = 4,
  parameter int          GAME_SECONDS    = 30,
  parameter int          MOLE_UP_SECONDS = 2,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter int          SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               start_btn,
  input  logic [N_MOLES-1:0] hit_btn,
  output logic [N_MOLES-1:0] mole_led,
  output logic [SCORE_W-1:0] score,
  output logic [6:0]         time_left,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam int                 IDX_W     = $clog2(N_MOLES);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]         SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [6:0]         GAME_S    = 7'(GAME_SECONDS);
  localparam logic [3:0]         UP_S      = 4'(MOLE_UP_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_UP    = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [N_MOLES-1:0]  mole_led_q, mole_led_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [6:0]          time_left_q, time_left_d;
  logic [3:0]          up_cnt_q, up_cnt_d;
  logic [IDX_W-1:0]    prev_idx_q, prev_idx_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic                tick_q, start_q;
  logic [N_MOLES-1:0]  hit_q;

  logic                sec_pulse;
  logic                start_rise;
  logic [N_MOLES-1:0]  hit_rise;
  logic                correct_hit;
  logic                wrong_hit;
  logic                in_game;
  logic [IDX_W-1:0]    cand_idx;
  logic [IDX_W-1:0]    spawn_idx;

  // Rising-edge detect on the level inputs; the events are used in the same
  // cycle they are seen.
  assign sec_pulse   = tick_1hz & ~tick_q;
  assign start_rise  = start_btn & ~start_q;
  assign hit_rise    = hit_btn & ~hit_q;

  assign correct_hit = |(hit_rise & mole_led_q);
  assign wrong_hit   = |(hit_rise & ~mole_led_q);
  assign in_game     = (state_q == S_SPAWN) || (state_q == S_UP) || (state_q == S_GAP);

  // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. It runs every cycle, so the
  // button timing of the player feeds into the mole choice.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Never light the same mole twice in a row. N_MOLES is a power of two, so
  // the +1 wraps modulo N_MOLES naturally.
  assign cand_idx  = lfsr_q[IDX_W-1:0];
  assign spawn_idx = (cand_idx == prev_idx_q) ? cand_idx + IDX_W'(1) : cand_idx;

  always_comb begin
    state_d     = state_q;
    mole_led_d  = mole_led_q;
    score_d     = score_q;
    time_left_d = time_left_q;
    up_cnt_d    = up_cnt_q;
    prev_idx_d  = prev_idx_q;

    case (state_q)
      S_IDLE: begin
        mole_led_d  = '0;
        time_left_d = GAME_S;
        if (start_rise) begin
          score_d = '0;
          state_d = S_SPAWN;
        end
      end

      S_SPAWN: begin
        prev_idx_d = spawn_idx;
        mole_led_d = N_MOLES'(1) << spawn_idx;
        up_cnt_d   = UP_S;
        state_d    = S_UP;
      end

      S_UP: begin
        if (correct_hit) begin
          // A correct hit wins over any wrong hit in the same cycle.
          if (score_q != SCORE_MAX) begin
            score_d = score_q + SCORE_W'(1);
          end
          mole_led_d = '0;
          state_d    = S_GAP;
        end else begin
          if (wrong_hit && (score_q != '0)) begin
            score_d = score_q - SCORE_W'(1);
          end
          if (sec_pulse) begin
            up_cnt_d = up_cnt_q - 4'd1;
            if (up_cnt_q == 4'd1) begin
              mole_led_d = '0;
              state_d    = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        mole_led_d = '0;
        if (sec_pulse) begin
          state_d = S_SPAWN;
        end
      end

      S_DONE: begin
        if (start_rise) begin
          score_d     = '0;
          time_left_d = GAME_S;
          state_d     = S_SPAWN;
        end
      end

      default: begin
        mole_led_d = '0;
        state_d    = S_IDLE;
      end
    endcase

    // The game clock runs in every in-game state. The final second overrides
    // whatever transition was chosen above, but the score update stays.
    if (in_game && sec_pulse) begin
      if (time_left_q == 7'd1) begin
        time_left_d = 7'd0;
        mole_led_d  = '0;
        state_d     = S_DONE;
      end else begin
        time_left_d = time_left_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mole_led_q  <= '0;
      score_q     <= '0;
      time_left_q <= GAME_S;
      up_cnt_q    <= '0;
      prev_idx_q  <= '0;
      lfsr_q      <= SEED_EFF;
      tick_q      <= 1'b0;
      start_q     <= 1'b0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      mole_led_q  <= mole_led_d;
      score_q     <= score_d;
      time_left_q <= time_left_d;
      up_cnt_q    <= up_cnt_d;
      prev_idx_q  <= prev_idx_d;
      lfsr_q      <= lfsr_d;
      tick_q      <= tick_1hz;
      start_q     <= start_btn;
      hit_q       <= hit_btn;
    end
  end

  assign mole_led  = mole_led_q;
  assign score     = score_q;
  assign time_left = time_left_q;
  assign game_over = (state_q == S_DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl with a 5-second game, 2-second
// moles, 4 moles and a 2-bit score, so saturation and game end come quickly.
module tb_whack_game_ctrl;

  localparam int GS   = 5;
  localparam int UPS  = 2;
  localparam int SMAX = 3;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       start_btn;
  logic [3:0] hit_btn;
  logic [3:0] mole_led;
  logic [1:0] score;
  logic [6:0] time_left;
  logic       game_over;
  logic [2:0] state;

  int n_checks;
  int n_errors;

  whack_game_ctrl #(
    .N_MOLES(4), .GAME_SECONDS(GS), .MOLE_UP_SECONDS(UPS),
    .LFSR_SEED(8'hA5), .SCORE_W(2)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_btn(start_btn),
    .hit_btn(hit_btn), .mole_led(mole_led), .score(score),
    .time_left(time_left), .game_over(game_over), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: game phase uses the documented state codes, the lit
  // mole is an index (-1 = none), everything else plain integers.
  int m_phase, m_led, m_score, m_time, m_up, m_prev, m_lfsr;
  int m_ptick, m_pstart, m_phit;

  task automatic model_reset();
    m_phase = 0; m_led = -1; m_score = 0; m_time = GS; m_up = 0;
    m_prev = 0; m_lfsr = 8'hA5; m_ptick = 0; m_pstart = 0; m_phit = 0;
  endtask

  task automatic model_update();
    int sec, srise, hr, cand, fb;
    int n_phase, n_led, n_score, n_time, n_up, n_prev;
    sec   = (tick_1hz && !m_ptick) ? 1 : 0;
    srise = (start_btn && !m_pstart) ? 1 : 0;
    hr    = int'(hit_btn) & ~m_phit & 15;
    n_phase = m_phase; n_led = m_led; n_score = m_score;
    n_time = m_time; n_up = m_up; n_prev = m_prev;
    case (m_phase)
      0: begin
        n_led = -1; n_time = GS;
        if (srise != 0) begin n_phase = 1; n_score = 0; end
      end
      1: begin
        cand = m_lfsr % 4;
        if (cand == m_prev) cand = (cand + 1) % 4;
        n_prev = cand; n_led = cand; n_up = UPS; n_phase = 2;
      end
      2: begin
        if (m_led >= 0 && ((hr >> m_led) & 1) != 0) begin
          n_score = (m_score < SMAX) ? m_score + 1 : SMAX;
          n_led = -1; n_phase = 3;
        end else begin
          if ((hr & ~(1 << m_led)) != 0 && m_score > 0) n_score = m_score - 1;
          if (sec != 0) begin
            n_up = m_up - 1;
            if (m_up == 1) begin n_led = -1; n_phase = 3; end
          end
        end
      end
      3: begin
        n_led = -1;
        if (sec != 0) n_phase = 1;
      end
      default: begin
        if (srise != 0) begin n_score = 0; n_time = GS; n_phase = 1; end
      end
    endcase
    if (m_phase >= 1 && m_phase <= 3 && sec != 0) begin
      if (m_time == 1) begin n_time = 0; n_led = -1; n_phase = 4; end
      else n_time = m_time - 1;
    end
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 255;
    m_phase = n_phase; m_led = n_led; m_score = n_score;
    m_time = n_time; m_up = n_up; m_prev = n_prev;
    m_ptick = int'(tick_1hz); m_pstart = int'(start_btn); m_phit = int'(hit_btn);
  endtask

  function automatic logic [16:0] exp_vec();
    logic [3:0] l;
    l = (m_led < 0) ? 4'd0 : 4'(1 << m_led);
    return {l, 2'(m_score), 7'(m_time), (m_phase == 4), 3'(m_phase)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {mole_led, score, time_left, game_over, state};
  endfunction

  // One clock with the current inputs; returns 1 time unit after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_1hz = 1'b0; start_btn = 1'b0; hit_btn = 4'd0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic press_start();
    start_btn = 1'b1; step();
    start_btn = 1'b0; step();
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mole_led !== 4'd0) begin n_errors++; $display("FAIL reset_mole_led got %h exp 0", mole_led); end
    n_checks++; if (score !== 2'd0) begin n_errors++; $display("FAIL reset_score got %0d exp 0", score); end
    n_checks++; if (time_left !== 7'(GS)) begin n_errors++; $display("FAIL reset_time_left got %0d exp %0d", time_left, GS); end
    n_checks++; if (game_over !== 1'b0) begin n_errors++; $display("FAIL reset_game_over got %b exp 0", game_over); end
    n_checks++; if (state !== 3'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", state); end
  endtask

  task automatic test_full_game();
    press_start();
    n_checks++; if (dut_vec() !== exp_vec()) begin n_errors++; $display("FAIL full_start got %h exp %h", dut_vec(), exp_vec()); end
    for (int k = 1; k <= GS; k++) begin
      for (int c = 0; c < 19; c++) begin
        step();
        n_checks++; if (dut_vec() !== exp_vec()) begin n_errors++; $display("FAIL full_cycle got %h exp %h", dut_vec(), exp_vec()); end
      end
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
      n_checks++; if (time_left !== 7'(GS - k)) begin n_errors++; $display("FAIL full_time_left got %0d exp %0d", time_left, GS - k); end
      n_checks++; if (dut_vec() !== exp_vec()) begin n_errors++; $display("FAIL full_tick got %h exp %h", dut_vec(), exp_vec()); end
    end
    n_checks++; if (state !== 3'd4 || game_over !== 1'b1 || score !== 2'd0 || mole_led !== 4'd0) begin
      n_errors++; $display("FAIL full_done got st=%0d go=%b sc=%0d led=%h exp st=4 go=1 sc=0 led=0", state, game_over, score, mole_led);
    end
  endtask

  task automatic test_correct_hit();
    start_btn = 1'b1; step();
    n_checks++; if (state !== 3'd1 || mole_led !== 4'd0 || score !== 2'd0 || time_left !== 7'(GS)) begin
      n_errors++; $display("FAIL restart_spawn got st=%0d led=%h sc=%0d t=%0d exp st=1 led=0 sc=0 t=%0d", state, mole_led, score, time_left, GS);
    end
    start_btn = 1'b0; step();
    n_checks++; if (state !== 3'd2 || !$onehot(mole_led)) begin n_errors++; $display("FAIL restart_up got st=%0d led=%h exp st=2 one-hot led", state, mole_led); end
    step(); step();
    hit_btn = 4'(1 << m_led); step();
    n_checks++; if (score !== 2'd1 || mole_led !== 4'd0 || state !== 3'd3) begin
      n_errors++; $display("FAIL correct_hit got sc=%0d led=%h st=%0d exp sc=1 led=0 st=3", score, mole_led, state);
    end
    hit_btn = 4'd0; step();
    tick_1hz = 1'b1; step();
    n_checks++; if (state !== 3'd1) begin n_errors++; $display("FAIL gap_to_spawn got st=%0d exp 1", state); end
    tick_1hz = 1'b0; step();
    n_checks++; if (dut_vec() !== exp_vec()) begin n_errors++; $display("FAIL respawn got %h exp %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_wrong_hits();
    int w;
    do_reset(); press_start();
    w = (m_led + 1 + int'($urandom_range(0, 2))) % 4;
    hit_btn = 4'(1 << w); step();
    n_checks++; if (score !== 2'd0 || state !== 3'd2) begin n_errors++; $display("FAIL wrong_at_zero got sc=%0d st=%0d exp sc=0 st=2", score, state); end
    hit_btn = 4'd0; step();
    hit_btn = 4'(1 << m_led); step(); hit_btn = 4'd0; step();
    tick_once();
    hit_btn = 4'(1 << m_led); step(); hit_btn = 4'd0; step();
    n_checks++; if (score !== 2'd2) begin n_errors++; $display("FAIL two_correct got %0d exp 2", score); end
    tick_once();
    w = (m_led + 1 + int'($urandom_range(0, 2))) % 4;
    hit_btn = 4'(1 << w); step();
    n_checks++; if (score !== 2'd1) begin n_errors++; $display("FAIL wrong_at_two got %0d exp 1", score); end
    hit_btn = 4'd0; step();
    hit_btn = 4'(1 << m_led); step(); hit_btn = 4'd0; step();
    tick_once();
    w = (m_led + 1 + int'($urandom_range(0, 2))) % 4;
    hit_btn = 4'((1 << m_led) | (1 << w)); step();
    n_checks++; if (score !== 2'd3 || state !== 3'd3) begin n_errors++; $display("FAIL correct_plus_wrong got sc=%0d st=%0d exp sc=3 st=3", score, state); end
    hit_btn = 4'd0; step();
  endtask

  task automatic test_final_tick_hit();
    do_reset(); press_start();
    tick_once(); tick_once(); tick_once(); tick_once();
    n_checks++; if (state !== 3'd2 || time_left !== 7'd1) begin n_errors++; $display("FAIL pre_final got st=%0d t=%0d exp st=2 t=1", state, time_left); end
    start_btn = 1'b1; step();
    n_checks++; if (state !== 3'd2) begin n_errors++; $display("FAIL start_in_game got st=%0d exp 2", state); end
    tick_1hz = 1'b1; hit_btn = 4'(1 << m_led); step();
    n_checks++; if (state !== 3'd4 || game_over !== 1'b1 || time_left !== 7'd0 || score !== 2'd1 || mole_led !== 4'd0) begin
      n_errors++; $display("FAIL final_hit got st=%0d go=%b t=%0d sc=%0d led=%h exp st=4 go=1 t=0 sc=1 led=0", state, game_over, time_left, score, mole_led);
    end
    tick_1hz = 1'b0; hit_btn = 4'd0; step();
    hit_btn = 4'hF; step(); hit_btn = 4'd0; step();
    n_checks++; if (score !== 2'd1 || state !== 3'd4) begin n_errors++; $display("FAIL done_hits got sc=%0d st=%0d exp sc=1 st=4", score, state); end
    for (int c = 0; c < 5; c++) step();
    n_checks++; if (state !== 3'd4) begin n_errors++; $display("FAIL held_start got st=%0d exp 4", state); end
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    n_checks++; if (state !== 3'd1 || score !== 2'd0 || time_left !== 7'(GS)) begin
      n_errors++; $display("FAIL new_game got st=%0d sc=%0d t=%0d exp st=1 sc=0 t=%0d", state, score, time_left, GS);
    end
    start_btn = 1'b0; step();
  endtask

  task automatic test_saturation();
    do_reset(); press_start();
    for (int k = 1; k <= 4; k++) begin
      hit_btn = 4'(1 << m_led); step();
      n_checks++; if (score !== 2'((k < SMAX) ? k : SMAX)) begin n_errors++; $display("FAIL saturate hit %0d got %0d exp %0d", k, score, (k < SMAX) ? k : SMAX); end
      hit_btn = 4'd0; step();
      if (k < 4) tick_once();
    end
  endtask

  task automatic test_reset_mid_game();
    tick_once();
    n_checks++; if (state !== 3'd2 || score !== 2'd3) begin n_errors++; $display("FAIL pre_reset got st=%0d sc=%0d exp st=2 sc=3", state, score); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (mole_led !== 4'd0 || score !== 2'd0 || time_left !== 7'(GS) || state !== 3'd0) begin
      n_errors++; $display("FAIL async_reset got led=%h sc=%0d t=%0d st=%0d exp led=0 sc=0 t=%0d st=0", mole_led, score, time_left, state, GS);
    end
    do_reset();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) tick_1hz = ~tick_1hz;
      if ($urandom_range(0, 39) == 0) start_btn = ~start_btn;
      r = int'($urandom_range(0, 9));
      if (r == 0 && m_led >= 0) hit_btn = 4'(1 << m_led);
      else if (r == 1) hit_btn = 4'($urandom_range(0, 15));
      else if (r > 4) hit_btn = 4'd0;
      step();
      n_checks++; if (dut_vec() !== exp_vec()) begin n_errors++; $display("FAIL random cycle %0d got %h exp %h", c, dut_vec(), exp_vec()); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; tick_1hz = 1'b0; start_btn = 1'b0; hit_btn = 4'd0;
    model_reset();
    test_reset();
    test_full_game();
    test_correct_hit();
    test_wrong_hits();
    test_final_tick_hit();
    test_saturation();
    test_reset_mid_game();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
